ibex_mem_arbiter: RTL
=====================

// Module: ibex_mem_arbiter
// PURPOSE
//  Shares one external memory port between the core's instruction-fetch and data (LSU) interfaces
//  in the FPGA SoC. Uses the same req/gnt/rvalid protocol on all three sides. Tracks outstanding
//  granted transactions in order and routes each rvalid/rdata/err back to the requester that issued it.
// PARAMETERS
//  MaxOutstanding  2   max granted-but-unanswered transactions, 1..4; sets source-FIFO depth
//  AddrWidth       32  address width, all ports
//  DataWidth       32  data width, all ports; BE width = DataWidth/8
// PORTS
//  clk_i          in   1    clock
//  rst_ni         in   1    asynchronous active-low reset
//  instr_req_i    in   1    fetch request; held until instr_gnt_o
//  instr_gnt_o    out  1    fetch grant
//  instr_rvalid_o out  1    fetch response valid
//  instr_addr_i   in   AW   fetch address
//  instr_rdata_o  out  DW   fetch read data
//  instr_err_o    out  1    fetch bus error
//  data_req_i     in   1    LSU request; held until data_gnt_o
//  data_gnt_o     out  1    LSU grant
//  data_rvalid_o  out  1    LSU response valid
//  data_we_i      in   1    LSU write enable
//  data_be_i      in   DW/8 LSU byte enables
//  data_addr_i    in   AW   LSU address
//  data_wdata_i   in   DW   LSU write data
//  data_rdata_o   out  DW   LSU read data
//  data_err_o     out  1    LSU bus error
//  mem_req_o / mem_gnt_i / mem_rvalid_i / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o / mem_rdata_i /
//  mem_err_i      shared downstream port; same widths and meanings as the data_* signals
//  protocol_err_o out  1    sticky: mem_rvalid_i seen with no transaction outstanding
// BEHAVIOUR
//  - Reset: every output is 0. Source FIFO is empty. Lock is clear. RR pointer selects DATA.
//  - Issue: the winner's fields are driven combinationally onto mem_*. Fetch always sends we=0, be=all-ones.
//    mem_req_o = winner_req & (count < MaxOutstanding).
//    When count == MaxOutstanding, all requests are masked, even if mem_rvalid_i pops in the same cycle.
//  - Grant: a grant goes only to the winner, and only when mem_gnt_i & mem_req_o.
//    On that cycle the winner's source ID is pushed to the FIFO (0 latency added).
//  - Lock: if mem_req_o=1 and mem_gnt_i=0, the winner is registered and held until it is granted.
//    This keeps mem_* stable per the protocol. A newly arriving higher-priority request waits.
//  - Response: on mem_rvalid_i, the head source is popped. rvalid/rdata/err go combinationally to that
//    source only. The other side's rvalid=0, and its rdata/err are forced to 0.
//  - Push and pop in the same cycle: count is unchanged. Count saturates at 0..MaxOutstanding.
//  - mem_rvalid_i with an empty FIFO: no requester receives rvalid, and protocol_err_o sets until reset.
//  - Reset mid-operation: FIFO is flushed and in-flight responses are dropped.
//    Downstream must also be reset.
// CONFIGURATION
//  IBEX_MEM_ARB_RR_EN defined: round-robin. After each grant, priority moves to the other requester.
//  IBEX_MEM_ARB_RR_EN undefined: fixed priority, DATA over INSTR. The RR pointer flop is not built.
// STRUCTURE
//  ibex_mem_arb_pkg: typedef enum logic {ARB_SRC_INSTR=1'b0, ARB_SRC_DATA=1'b1} arb_src_e;
//    localparam MaxOutstandingLimit = 4.
//  Sub-module ibex_mem_arb_fifo: arb_src_e FIFO, depth MaxOutstanding.
//    Ports: push/pop/head/count/empty/full.
//  Top level holds arbitration, lock, RR pointer, response routing and the protocol_err flag.
// TESTING
//  1. Data only: data_req with addr 0x100, we=1, be=0xF, wdata 0xDEADBEEF; mem_gnt given the same cycle
//     -> data_gnt_o=1 that cycle; mem_* carries the exact fields; rvalid 2 cycles later goes to data only.
//  2. Both request every cycle, fixed priority -> 3 grants all to DATA.
//     With IBEX_MEM_ARB_RR_EN: grants go D,I,D.
//  3. Lock: INSTR wins and mem_gnt=0 for 3 cycles, then data_req rises
//     -> mem_addr_o stays the fetch address until granted; DATA is granted next.
//  4. MaxOutstanding=2: two grants with no rvalid -> mem_req_o=0 and both gnt=0.
//     The cycle after the first rvalid, mem_req_o=1 again.
//  5. Ordering: grant I(0x0) then D(0x40); rvalids carry 0x11 then 0x22
//     -> instr_rdata_o=0x11, then data_rdata_o=0x22; mem_err_i on the second -> data_err_o=1 only.
//  6. mem_rvalid_i while empty -> no rvalid out, protocol_err_o=1 and sticky.
//     rst_ni pulse mid-transaction -> all outputs 0, count=0.

Source files
------------

// File: rtl/ibex_mem_arb_pkg.sv
// ibex_mem_arb_pkg
// Shared types and limits for the instruction/data memory arbiter.
//   arb_src_e           : which requester issued a transaction
//   MaxOutstandingLimit : upper bound for the MaxOutstanding parameter
package ibex_mem_arb_pkg;

  typedef enum logic {
    ARB_SRC_INSTR = 1'b0,
    ARB_SRC_DATA  = 1'b1
  } arb_src_e;

  localparam int unsigned MaxOutstandingLimit = 4;

endpackage

// File: rtl/ibex_mem_arb_fifo.sv
// ibex_mem_arb_fifo
// In-order FIFO of source IDs for granted, not yet answered memory transactions.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : store push_src_i (ignored when full)
//   push_src_i    : source ID of the transaction just granted
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : source ID of the oldest outstanding transaction
//   count_o       : number of stored entries, 0..Depth
//   empty_o/full_o: occupancy flags
module ibex_mem_arb_fifo
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  arb_src_e                     push_src_i,
  input  logic                         pop_i,
  output arb_src_e                     head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  arb_src_e              entry_r [Depth];
  logic [PtrWidth-1:0]   wr_ptr_r;
  logic [PtrWidth-1:0]   rd_ptr_r;
  logic [CntWidth-1:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(Depth - 1)) begin
      return {PtrWidth{1'b0}};
    end else begin
      return ptr + PtrWidth'(1);
    end
  endfunction

  assign empty_o   = (count_r == {CntWidth{1'b0}});
  assign full_o    = (count_r == CntWidth'(Depth));
  assign count_o   = count_r;
  assign head_o    = entry_r[rd_ptr_r];
  // Guarding here keeps the count saturated at 0..Depth whatever the caller does.
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        entry_r[i] <= ARB_SRC_INSTR;
      end
      wr_ptr_r <= {PtrWidth{1'b0}};
      rd_ptr_r <= {PtrWidth{1'b0}};
      count_r  <= {CntWidth{1'b0}};
    end else begin
      if (push_ok_s) begin
        entry_r[wr_ptr_r] <= push_src_i;
        wr_ptr_r          <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CntWidth'(1);
        2'b01:   count_r <= count_r - CntWidth'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
// Shares one req/gnt/rvalid memory port between instruction fetch and the LSU.
// Granted transactions are tracked in order so each response returns to its issuer.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   instr_*          : fetch requester (read only; sent as we=0, be=all ones)
//   data_*           : LSU requester
//   mem_*            : shared downstream port
//   protocol_err_o   : sticky, a response arrived with nothing outstanding
// Build option: define IBEX_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise DATA has fixed priority over INSTR.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_req_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   protocol_err_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  arb_src_e              winner_src_s;
  arb_src_e              prio_src_s;
  logic                  winner_req_s;
  logic                  can_issue_s;
  logic                  grant_s;
  logic                  pop_s;
  arb_src_e              fifo_head_s;
  logic [CntWidth-1:0]   fifo_count_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic                  lock_r;
  arb_src_e              lock_src_r;
  logic                  protocol_err_r;

`ifdef IBEX_MEM_ARB_RR_EN
  arb_src_e              rr_ptr_r;

  // Round-robin pointer: after each grant the other requester gets priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= ARB_SRC_DATA;
    end else if (grant_s) begin
      rr_ptr_r <= (winner_src_s == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign prio_src_s = rr_ptr_r;
`else
  assign prio_src_s = ARB_SRC_DATA;
`endif

  // Winner selection; a stalled winner stays locked so mem_* is stable until granted.
  always_comb begin
    winner_src_s = ARB_SRC_DATA;
    if (lock_r) begin
      winner_src_s = lock_src_r;
    end else if (data_req_i && instr_req_i) begin
      winner_src_s = prio_src_s;
    end else if (instr_req_i) begin
      winner_src_s = ARB_SRC_INSTR;
    end else begin
      winner_src_s = ARB_SRC_DATA;
    end
  end

  assign winner_req_s = (winner_src_s == ARB_SRC_DATA) ? data_req_i : instr_req_i;
  // A response popping in this cycle does not free a slot until the next cycle.
  assign can_issue_s  = (fifo_count_s < CntWidth'(MaxOutstanding)) & ~fifo_full_s;
  assign mem_req_o    = winner_req_s & can_issue_s;
  assign grant_s      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o  = grant_s & (winner_src_s == ARB_SRC_INSTR);
  assign data_gnt_o   = grant_s & (winner_src_s == ARB_SRC_DATA);

  // Drive the winner's request fields downstream; idle fields read as zero.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = {BeWidth{1'b0}};
    mem_addr_o  = {AddrWidth{1'b0}};
    mem_wdata_o = {DataWidth{1'b0}};
    if (winner_req_s) begin
      case (winner_src_s)
        ARB_SRC_DATA: begin
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end
        ARB_SRC_INSTR: begin
          mem_we_o    = 1'b0;
          mem_be_o    = {BeWidth{1'b1}};
          mem_addr_o  = instr_addr_i;
          mem_wdata_o = {DataWidth{1'b0}};
        end
        default: begin
          mem_we_o    = 1'b0;
          mem_be_o    = {BeWidth{1'b0}};
          mem_addr_o  = {AddrWidth{1'b0}};
          mem_wdata_o = {DataWidth{1'b0}};
        end
      endcase
    end else begin
      mem_we_o = 1'b0;
    end
  end

  // Lock: set when a request is presented but not granted, cleared on grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_r     <= 1'b0;
      lock_src_r <= ARB_SRC_INSTR;
    end else if (grant_s) begin
      lock_r     <= 1'b0;
      lock_src_r <= lock_src_r;
    end else if (mem_req_o) begin
      lock_r     <= 1'b1;
      lock_src_r <= winner_src_s;
    end else begin
      lock_r     <= lock_r;
      lock_src_r <= lock_src_r;
    end
  end

  ibex_mem_arb_fifo #(
    .Depth (MaxOutstanding)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (grant_s),
    .push_src_i (winner_src_s),
    .pop_i      (pop_s),
    .head_o     (fifo_head_s),
    .count_o    (fifo_count_s),
    .empty_o    (fifo_empty_s),
    .full_o     (fifo_full_s)
  );

  // Responses go only to the head source; the other side sees all zeros.
  assign pop_s          = mem_rvalid_i & ~fifo_empty_s;
  assign instr_rvalid_o = pop_s & (fifo_head_s == ARB_SRC_INSTR);
  assign data_rvalid_o  = pop_s & (fifo_head_s == ARB_SRC_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : {DataWidth{1'b0}};
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : {DataWidth{1'b0}};
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;

  // Sticky flag for an unsolicited response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      protocol_err_r <= 1'b0;
    end else if (mem_rvalid_i && fifo_empty_s) begin
      protocol_err_r <= 1'b1;
    end else begin
      protocol_err_r <= protocol_err_r;
    end
  end

  assign protocol_err_o = protocol_err_r;

endmodule
